uart_hex_cmd: RTL and testbench

Upstream stage for the 4-digit hex display. It consumes the byte stream from the UART receiver (one-cycle valid strobe per byte) and parses ASCII hex digits into a shadow register. On a line terminator it commits the value to the 16-bit display word that feeds the display driver. Malformed input and stalled partial lines are discarded, and an error is flagged.

---
 rtl/uart_hex_cmd.sv | 136 +++++++++++++
 tb/tb_uart_hex_cmd.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_cmd.sv
// uart_hex_cmd: parses a UART byte stream of ASCII hex digits into a shadow
// register and commits it to the display word on CR/LF. Bad characters and
// stalled partial entries are discarded and flagged with a one-cycle err.
module uart_hex_cmd #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic [4*DIGITS-1:0]   data,
    output logic                  data_valid,
    output logic                  err,
    output logic                  busy
);

    localparam int W    = 4 * DIGITS;
    localparam int CNTW = $clog2(DIGITS + 1);
    localparam int TW   = $clog2(TIMEOUT);

    typedef enum logic {IDLE, COLLECT} state_t;
    typedef enum logic [1:0] {C_HEX, C_TERM, C_SKIP, C_BAD} cls_t;

    state_t            state_q, state_d;
    logic [W-1:0]      shadow_q, shadow_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [W-1:0]      data_d;
    logic              data_valid_d, err_d;
    cls_t              cls;
    logic [3:0]        nibble;

    // Classify the incoming byte and extract its nibble value.
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        cls    = C_BAD;
        nibble = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            cls    = C_HEX;
            nibble = 4'(rx_data - 8'h30);
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            cls    = C_HEX;
            nibble = 4'(rx_data - 8'h37);
        end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            cls    = C_HEX;
            nibble = 4'(rx_data - 8'h57);
        end else if (rx_data == 8'h0D || rx_data == 8'h0A) begin
            cls = C_TERM;
        end else if (rx_data == 8'h5F || rx_data == 8'h20) begin
            cls = C_SKIP;
        end
    end

    // Next-state and next-output logic for the IDLE/COLLECT parser.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        count_d      = count_q;
        tmo_d        = '0;
        data_d       = data;
        data_valid_d = 1'b0;
        err_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (cls == C_HEX) begin
                        shadow_d = W'(nibble);
                        count_d  = CNTW'(1);
                        state_d  = COLLECT;
                    end else if (cls == C_BAD) begin
                        err_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    unique case (cls)
                        C_HEX: begin
                            // Older digits fall off the top: the last DIGITS digits win.
                            shadow_d = (shadow_q << 4) | W'(nibble);
                            if (count_q < CNTW'(DIGITS))
                                count_d = count_q + CNTW'(1);
                        end
                        C_SKIP: ;
                        C_TERM: begin
                            data_d       = shadow_q;
                            data_valid_d = 1'b1;
                            count_d      = '0;
                            state_d      = IDLE;
                        end
                        C_BAD: begin
                            err_d    = 1'b1;
                            shadow_d = '0;
                            count_d  = '0;
                            state_d  = IDLE;
                        end
                    endcase
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // Stalled partial line: drop it, keep the committed word.
                    err_d    = 1'b1;
                    shadow_d = '0;
                    count_d  = '0;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            data       <= data_d;
            data_valid <= data_valid_d;
            err        <= err_d;
        end
    end

    assign busy = (state_q == COLLECT);

endmodule

// File: tb/tb_uart_hex_cmd.sv
// tb_uart_hex_cmd: directed and random byte streams driven into uart_hex_cmd;
// a line-level reference model queues expected commits/errors and a monitor
// process compares every DUT pulse, plus busy and data each cycle.
module tb_uart_hex_cmd;

    localparam int DIGITS  = 4;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [15:0] data;
    logic        data_valid, err, busy;

    uart_hex_cmd #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .data(data), .data_valid(data_valid), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [15:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    bit  armed  = 0;

    // Reference model: a line is a list of digits typed since the line began.
    bit          m_pending = 0;
    int          m_digits[$];
    int          m_idle = 0;
    logic [15:0] m_data = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - int'("0");
        if (b >= "a" && b <= "f") return int'(b) - int'("a") + 10;
        if (b >= "A" && b <= "F") return int'(b) - int'("A") + 10;
        return -1;
    endfunction

    function automatic bit is_term(input logic [7:0] b);
        return b == 8'd13 || b == 8'd10;
    endfunction

    function automatic bit is_skip(input logic [7:0] b);
        return b == "_" || b == " ";
    endfunction

    function automatic logic [15:0] line_value();
        int v = 0;
        int first = (m_digits.size() > DIGITS) ? m_digits.size() - DIGITS : 0;
        for (int i = first; i < m_digits.size(); i++) v = v * 16 + m_digits[i];
        return 16'(v);
    endfunction

    task automatic push_ev(input bit is_e, input logic [15:0] v);
        ev_t e;
        e.cyc = cyc + 1;
        e.is_err = is_e;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] b);
        if (r) begin
            m_pending = 0; m_digits.delete(); m_idle = 0; m_data = 16'h0;
            armed = 1;
        end else if (v) begin
            m_idle = 0;
            if (hexval(b) >= 0) begin
                m_digits.push_back(hexval(b));
                m_pending = 1;
            end else if (is_term(b)) begin
                if (m_pending) begin
                    m_data = line_value();
                    push_ev(0, m_data);
                end
                m_pending = 0; m_digits.delete();
            end else if (!is_skip(b)) begin
                push_ev(1, m_data);
                m_pending = 0; m_digits.delete();
            end
        end else if (m_pending) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                push_ev(1, m_data);
                m_pending = 0; m_digits.delete(); m_idle = 0;
            end
        end
    endtask

    task automatic drive_cycle(input logic r, input logic v, input logic [7:0] b);
        @(negedge clk);
        rst = r; rx_valid = v; rx_data = b;
        model_step(r, v, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 8'h00);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            drive_cycle(0, 1, s[i]);
            idle(gap);
        end
    endtask

    // Monitor: sample just after each active edge and compare against the model.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (armed) begin
                ev_t e;
                check("busy", busy, m_pending);
                check("data", data, m_data);
                if (data_valid && err) check("dv_err_overlap", 1, 0);
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    check(e.is_err ? "missed_err" : "missed_commit", 0, 1);
                end
                if (data_valid || err) begin
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                        check("unexpected_pulse", {data_valid, err}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_kind_err", err, e.is_err);
                        check("pulse_kind_dv", data_valid, !e.is_err);
                        if (!e.is_err) check("commit_value", data, e.val);
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized byte streams.
    initial begin
        string hs = "0123456789abcdefABCDEF";
        logic [7:0] b;

        repeat (3) drive_cycle(1, 0, 8'h00);
        idle(10);
        check("reset_data", data, 16'h0000);
        check("reset_busy", busy, 0);

        send_str("1aF3\r", 15);
        check("commit_1AF3", data, 16'h1AF3);

        send_str("BE\r\n", 0);
        idle(3);
        check("commit_00BE", data, 16'h00BE);
        send_str("12345\r", 0);
        idle(3);
        check("commit_2345", data, 16'h2345);

        send_str("12G34\r", 1);
        idle(3);
        check("commit_0034", data, 16'h0034);

        send_str("7", 0);
        idle(TIMEOUT);
        idle(1);
        check("timeout_busy", busy, 0);
        send_str("8\r", 0);
        idle(3);
        check("commit_0008", data, 16'h0008);

        send_str("7", 0);
        idle(TIMEOUT - 1);
        send_str("8", 0);
        idle(2);
        check("expiry_byte_busy", busy, 1);
        send_str("\r", 0);
        idle(3);
        check("commit_0078", data, 16'h0078);

        send_str("AB", 0);
        drive_cycle(1, 0, 8'h00);
        idle(1);
        check("mid_reset_data", data, 16'h0000);
        send_str("\r", 2);
        send_str("C\r", 0);
        idle(3);
        check("commit_000C", data, 16'h000C);

        for (int n = 0; n < 1500; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 1) begin
                drive_cycle(1, 0, 8'h00);
                continue;
            end else if (r < 60) begin
                b = hs[$urandom_range(0, hs.len() - 1)];
            end else if (r < 75) begin
                b = ($urandom_range(0, 1) != 0) ? 8'd13 : 8'd10;
            end else if (r < 85) begin
                b = ($urandom_range(0, 1) != 0) ? "_" : " ";
            end else if (r < 92) begin
                do b = 8'($urandom_range(0, 255));
                while (hexval(b) >= 0 || is_term(b) || is_skip(b));
            end else begin
                idle($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
                continue;
            end
            drive_cycle(0, 1, b);
            if ($urandom_range(0, 1) != 0) idle($urandom_range(0, 3));
        end

        idle(5);
        check("events_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
